// File: rtl/carregador_bandeja_pkg.sv
// Shared types and constants for the tray loader: FSM state encoding,
// BCD digit widths and default tray capacity.
package bandeja_pkg;

  localparam int unsigned UNI_W       = 4;
  localparam int unsigned DEZ_W       = 2;
  localparam int unsigned CAP_DEZ_DEF = 2;
  localparam int unsigned CAP_UNI_DEF = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_RELEASE,
    S_FULL,
    S_ERROR
  } estado_t;

endpackage

// File: rtl/carregador_bandeja_if.sv
// Handshake and status bundle between the tray loader and its environment
// (feeder acks, consumer removals, BCD level and status flags).
interface carregador_bandeja_if;
  import bandeja_pkg::*;

  logic             iniciar;
  logic             peca_ok;
  logic             retirar;
  logic             pedido;
  logic [UNI_W-1:0] unidades_bandeja;
  logic [DEZ_W-1:0] dezenas_bandeja;
  logic             cheia;
  logic             vazia;
  logic             ocupado;
  logic             erro;

  modport master (
    output iniciar, peca_ok, retirar,
    input  pedido, unidades_bandeja, dezenas_bandeja, cheia, vazia, ocupado, erro
  );

  modport slave (
    input  iniciar, peca_ok, retirar,
    output pedido, unidades_bandeja, dezenas_bandeja, cheia, vazia, ocupado, erro
  );

endinterface

// File: rtl/carregador_bandeja_contador.sv
// Two-digit BCD up/down counter holding the tray level; saturates at 00
// and at the configured capacity. Simultaneous inc and dec hold the level.
module bcd_contador_ud
  import bandeja_pkg::*;
#(
  parameter int unsigned CAP_DEZENAS  = CAP_DEZ_DEF,
  parameter int unsigned CAP_UNIDADES = CAP_UNI_DEF
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [UNI_W-1:0] unidades_o,
  output logic [DEZ_W-1:0] dezenas_o,
  output logic             cheia_o,
  output logic             vazia_o
);

  localparam logic [UNI_W-1:0] CAP_U = UNI_W'(CAP_UNIDADES);
  localparam logic [DEZ_W-1:0] CAP_D = DEZ_W'(CAP_DEZENAS);

  logic [UNI_W-1:0] uni_q, uni_d;
  logic [DEZ_W-1:0] dez_q, dez_d;

  assign cheia_o    = (dez_q == CAP_D) && (uni_q == CAP_U);
  assign vazia_o    = (dez_q == '0) && (uni_q == '0);
  assign unidades_o = uni_q;
  assign dezenas_o  = dez_q;

  always_comb begin
    uni_d = uni_q;
    dez_d = dez_q;
    if (inc_i && !dec_i && !cheia_o) begin
      if (uni_q == UNI_W'(9)) begin
        uni_d = '0;
        dez_d = dez_q + 1'b1;
      end else begin
        uni_d = uni_q + 1'b1;
      end
    end else if (dec_i && !inc_i && !vazia_o) begin
      if (uni_q == '0) begin
        uni_d = UNI_W'(9);
        dez_d = dez_q - 1'b1;
      end else begin
        uni_d = uni_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      uni_q <= '0;
      dez_q <= '0;
    end else begin
      uni_q <= uni_d;
      dez_q <= dez_d;
    end
  end

endmodule

// File: rtl/carregador_bandeja.sv
// Tray loader: requests items from a feeder one handshake at a time until the
// tray is full. Optional watchdog enabled by defining CARREGADOR_TIMEOUT_EN.
module carregador_bandeja
  import bandeja_pkg::*;
#(
  parameter int unsigned CAP_DEZENAS    = CAP_DEZ_DEF,
  parameter int unsigned CAP_UNIDADES   = CAP_UNI_DEF,
  parameter int unsigned TIMEOUT_CICLOS = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  carregador_bandeja_if.slave  bus
);

  if (CAP_UNIDADES > 9 || CAP_DEZENAS > 3 || TIMEOUT_CICLOS == 0) begin : g_param_invalido
    $error("carregador_bandeja: invalid capacity digits or zero timeout");
  end

  estado_t estado_q, estado_d;
  logic    inc;
  logic    cheia;
  logic    vazia;
  logic    timeout;

  assign inc = (estado_q == S_REQUEST) && bus.peca_ok;

  bcd_contador_ud #(
    .CAP_DEZENAS  (CAP_DEZENAS),
    .CAP_UNIDADES (CAP_UNIDADES)
  ) u_nivel (
    .clk        (clk),
    .rst_i      (reset),
    .inc_i      (inc),
    .dec_i      (bus.retirar),
    .unidades_o (bus.unidades_bandeja),
    .dezenas_o  (bus.dezenas_bandeja),
    .cheia_o    (cheia),
    .vazia_o    (vazia)
  );

`ifdef CARREGADOR_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CICLOS + 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            em_espera;
  logic            entrada;

  assign em_espera = (estado_q == S_REQUEST) || (estado_q == S_RELEASE);
  assign entrada   = ((estado_d == S_REQUEST) || (estado_d == S_RELEASE)) && (estado_d != estado_q);
  // Fires on the last allowed waiting cycle, so ERROR is entered exactly
  // TIMEOUT_CICLOS cycles after the last entry or increment.
  assign timeout   = em_espera && (wdog_q == WD_W'(TIMEOUT_CICLOS - 1));

  always_comb begin
    wdog_d = '0;
    if (em_espera && !entrada && !inc) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign bus.erro = (estado_q == S_ERROR);
`else
  assign timeout  = 1'b0;
  assign bus.erro = 1'b0;
`endif

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      S_IDLE, S_ERROR: begin
        if (bus.iniciar) begin
          estado_d = cheia ? S_FULL : S_REQUEST;
        end
      end
      S_REQUEST: begin
        if (bus.peca_ok) begin
          estado_d = S_RELEASE;
        end else if (timeout) begin
          estado_d = S_ERROR;
        end
      end
      S_RELEASE: begin
        if (!bus.peca_ok) begin
          estado_d = cheia ? S_FULL : S_REQUEST;
        end else if (timeout) begin
          estado_d = S_ERROR;
        end
      end
      S_FULL: begin
        // A removal racing the RELEASE->FULL edge can leave FULL below capacity.
        if (!cheia || (bus.retirar && !vazia)) begin
          estado_d = S_IDLE;
        end
      end
      default: estado_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= S_IDLE;
    end else begin
      estado_q <= estado_d;
    end
  end

  assign bus.pedido  = (estado_q == S_REQUEST);
  assign bus.ocupado = (estado_q == S_REQUEST) || (estado_q == S_RELEASE);
  assign bus.cheia   = cheia;
  assign bus.vazia   = vazia;

endmodule

// File: tb/tb_carregador_bandeja.sv
// Scoreboard bench for carregador_bandeja: stimulus drives inputs and pushes
// expected outputs from a reference model; a monitor pops and compares.
module tb_carregador_bandeja;

  localparam int CAP  = 29;
  localparam int T_WD = 16;
`ifdef CARREGADOR_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  typedef enum {M_IDLE, M_REQ, M_REL, M_FULL, M_ERR} mfase_t;

  typedef struct {
    int alvo;
    int nivel;
    bit cheia;
    bit vazia;
    bit ocupado;
    bit pedido;
    bit erro;
  } esperado_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  esperado_t fila[$];

  mfase_t m_fase = M_IDLE;
  int     m_nivel = 0;
  int     m_wd = 0;
  int     esp = 0;

  carregador_bandeja_if bus();

  carregador_bandeja #(
    .CAP_DEZENAS    (2),
    .CAP_UNIDADES   (9),
    .TIMEOUT_CICLOS (T_WD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit estourou();
    m_wd++;
    return WD_ON && (m_wd >= T_WD);
  endfunction

  // Spec-level model: level as an integer, phase as a plain enum.
  function automatic void modelo(input bit r, input bit ini, input bit ok, input bit ret);
    int     novo;
    mfase_t prox;
    if (r) begin
      m_nivel = 0;
      m_fase  = M_IDLE;
      m_wd    = 0;
      return;
    end
    novo = m_nivel;
    if (m_fase == M_REQ && ok) begin
      if (!ret) novo = m_nivel + 1;
    end else if (ret && m_nivel > 0) begin
      novo = m_nivel - 1;
    end
    prox = m_fase;
    case (m_fase)
      M_IDLE, M_ERR: if (ini) begin
        prox = (m_nivel == CAP) ? M_FULL : M_REQ;
        m_wd = 0;
      end
      M_REQ: if (ok) begin
        prox = M_REL;
        m_wd = 0;
      end else if (estourou()) begin
        prox = M_ERR;
      end
      M_REL: if (!ok) begin
        prox = (m_nivel == CAP) ? M_FULL : M_REQ;
        m_wd = 0;
      end else if (estourou()) begin
        prox = M_ERR;
      end
      M_FULL: if (novo < CAP) prox = M_IDLE;
      default: prox = M_IDLE;
    endcase
    m_nivel = novo;
    m_fase  = prox;
  endfunction

  task automatic passo(input bit r, input bit ini, input bit ok, input bit ret);
    esperado_t e;
    @(posedge clk);
    #1;
    reset       = r;
    bus.iniciar = ini;
    bus.peca_ok = ok;
    bus.retirar = ret;
    modelo(r, ini, ok, ret);
    e.alvo    = cyc + 1;
    e.nivel   = m_nivel;
    e.cheia   = (m_nivel == CAP);
    e.vazia   = (m_nivel == 0);
    e.ocupado = (m_fase == M_REQ) || (m_fase == M_REL);
    e.pedido  = (m_fase == M_REQ);
    e.erro    = (m_fase == M_ERR);
    fila.push_back(e);
  endtask

  task automatic checar(input string nome, input logic [7:0] got, input int exp);
    tests++;
    if (got !== 8'(exp)) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s cycle %0d: got %0d expected %0d", nome, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    esperado_t e;
    while (fila.size() > 0 && fila[0].alvo <= cyc) begin
      e = fila.pop_front();
      checar("unidades", 8'(bus.unidades_bandeja), e.nivel % 10);
      checar("dezenas",  8'(bus.dezenas_bandeja),  e.nivel / 10);
      checar("cheia",    8'(bus.cheia),   int'(e.cheia));
      checar("vazia",    8'(bus.vazia),   int'(e.vazia));
      checar("ocupado",  8'(bus.ocupado), int'(e.ocupado));
      checar("pedido",   8'(bus.pedido),  int'(e.pedido));
      checar("erro",     8'(bus.erro),    int'(e.erro));
    end
  end

  // Feeder acks each request within two cycles; stops acking at the target.
  task automatic encher_ate(input int alvo);
    int budget = 0;
    bit ok;
    passo(0, 1, 0, 0);
    while (!(m_nivel == alvo && (m_fase == M_REQ || m_fase == M_FULL)) && budget < 400) begin
      if (m_fase == M_REQ && m_nivel < alvo) begin
        ok  = (esp >= 1) || ($urandom_range(0, 1) == 1);
        esp = ok ? 0 : esp + 1;
      end else begin
        ok  = 1'b0;
        esp = 0;
      end
      passo(0, m_fase == M_IDLE, ok, 0);
      budget++;
    end
    tests++;
    if (budget >= 400) begin
      fails++;
      $display("FAIL fill_budget: level %0d expected %0d within 400 cycles", m_nivel, alvo);
    end
  endtask

  initial begin
    bit r, ini, ok, ret;
    reset       = 1'b1;
    bus.iniciar = 1'b0;
    bus.peca_ok = 1'b0;
    bus.retirar = 1'b0;

    repeat (2) passo(1, 0, 0, 0);

    // Fill 00 -> 29, then one removal from FULL.
    encher_ate(CAP);
    repeat (2) passo(0, 0, 0, 0);
    passo(0, 0, 0, 1);
    passo(0, 0, 0, 0);

    // BCD carry 09 -> 10 and borrow 10 -> 09.
    passo(1, 0, 0, 0);
    encher_ate(9);
    passo(0, 0, 1, 0);
    passo(0, 0, 0, 0);
    passo(0, 0, 0, 1);
    passo(0, 0, 0, 0);

    // Ack and removal in the same cycle at level 05.
    passo(1, 0, 0, 0);
    encher_ate(5);
    passo(0, 0, 1, 1);
    passo(0, 0, 0, 0);

    // Removals at empty are ignored.
    passo(1, 0, 0, 0);
    repeat (3) begin
      passo(0, 0, 0, 1);
      passo(0, 0, 0, 0);
    end

    // Held ack counts once; reset mid-handshake discards the ack.
    passo(1, 0, 0, 0);
    passo(0, 1, 0, 0);
    repeat (10) passo(0, 0, 1, 0);
    passo(0, 0, 0, 0);
    encher_ate(12);
    passo(1, 0, 1, 0);
    passo(0, 0, 0, 0);

    // Starved feeder: watchdog (when compiled in) then restart.
    passo(1, 0, 0, 0);
    passo(0, 1, 0, 0);
    repeat (20) passo(0, 0, 0, 0);
    passo(0, 1, 0, 0);
    repeat (3) passo(0, 0, 0, 0);

    repeat (3000) begin
      r   = ($urandom_range(0, 99) == 0);
      ini = ($urandom_range(0, 3) == 0);
      if (m_fase == M_REQ)      ok = ($urandom_range(0, 2) != 0);
      else if (m_fase == M_REL) ok = ($urandom_range(0, 2) == 0);
      else                      ok = ($urandom_range(0, 7) == 0);
      ret = ($urandom_range(0, 5) == 0);
      passo(r, ini, ok, ret);
    end

    repeat (3) @(posedge clk);
    tests++;
    if (fila.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", fila.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/carregador_bandeja.md
CARREGADOR_BANDEJA -- requirements
Module: carregador_bandeja

Interface
REQ-001 Parameter CAP_DEZENAS, default 2, tens digit of tray capacity (0..3).
REQ-002 Parameter CAP_UNIDADES, default 9, units digit of tray capacity (0..9).
REQ-003 Parameter TIMEOUT_CICLOS, default 1000, watchdog limit in clock cycles; used only with the watchdog compiled in.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 iniciar  in  1  start a refill cycle; level-sampled in IDLE and ERROR.
REQ-007 peca_ok  in  1  feeder acknowledges that one item was placed in the tray.
REQ-008 retirar  in  1  one item removed by the consumer; a 1-cycle pulse per item.
REQ-009 pedido  out  1  request to the feeder for one item.
REQ-010 unidades_bandeja  out  4  BCD units digit of the tray level.
REQ-011 dezenas_bandeja  out  2  BCD tens digit of the tray level.
REQ-012 cheia, vazia, ocupado, erro  out  1 each  level equals capacity; level is 00; FSM not in IDLE/FULL/ERROR; watchdog fault.

Function
REQ-013 FSM states SHALL be IDLE, REQUEST, RELEASE, FULL and ERROR.
REQ-014 IDLE: iniciar=1 and level<capacity -> REQUEST; iniciar=1 and level==capacity -> FULL.
REQ-015 REQUEST: pedido=1; first cycle with peca_ok=1 -> level+1 at that edge, next state RELEASE.
REQ-016 RELEASE: pedido=0; wait for peca_ok=0; then -> FULL if level==capacity, else -> REQUEST (one item per full handshake, never two per ack pulse).
REQ-017 FULL: pedido=0; retirar leaving level<capacity -> IDLE.
REQ-018 Level SHALL count BCD: units 9+1 -> 0 with tens+1; units 0-1 -> 9 with tens-1.
REQ-019 retirar at level 00 SHALL be ignored; no wrap to 99 or to capacity.
REQ-020 Increment and retirar in the same cycle SHALL leave the level unchanged, while the FSM still advances to RELEASE.
REQ-021 Level SHALL never exceed capacity; the FSM cannot request at capacity.
REQ-022 cheia, vazia and ocupado SHALL be combinational decodes of the registered level and state; pedido SHALL be a decode of the registered state only.

Reset
REQ-023 reset=1 SHALL force, at the next edge: state IDLE, level 00, pedido=0, erro=0, watchdog=0, so cheia=0, vazia=1, ocupado=0.
REQ-024 reset SHALL dominate all other inputs, including mid-handshake; an item acknowledged in the reset cycle SHALL NOT be counted.

Configuration
REQ-025 Macro CARREGADOR_TIMEOUT_EN defined: a watchdog counter SHALL clear on entry to REQUEST/RELEASE and on every level increment, and count each cycle in those states.
REQ-026 With the macro, reaching TIMEOUT_CICLOS SHALL move the FSM to ERROR: erro=1, pedido=0; iniciar=1 -> REQUEST with erro=0; level is kept.
REQ-027 Macro undefined: no watchdog logic; erro tied to 0; ERROR unreachable; REQUEST/RELEASE wait indefinitely.

Structure
REQ-028 Package bandeja_pkg SHALL hold the FSM state typedef, the BCD digit widths (4 units, 2 tens) and the default capacity constants, shared with bandeja.
REQ-029 The level SHALL be a sub-module bcd_contador_ud (2-digit BCD up/down counter with sync reset, inc, dec and saturation at 00/capacity) instantiated once.

Verification
REQ-030 Reset, iniciar=1, feeder acks each pedido within 2 cycles -> level 00 -> 29, cheia=1, state FULL, pedido=0, 29 handshakes counted.
REQ-031 Level 09, one handshake -> level 10 (units wrap 9->0, tens 0->1); retirar at 10 -> 09.
REQ-032 Level 05 in REQUEST, peca_ok=1 and retirar=1 in the same cycle -> level stays 05, state RELEASE.
REQ-033 Level 00, retirar pulses x3 -> level stays 00, vazia=1; level 29 FULL, retirar -> 28, state IDLE.
REQ-034 peca_ok held high 10 cycles -> exactly one increment; reset asserted during REQUEST at level 12 -> level 00, pedido=0 next edge.
REQ-035 With CARREGADOR_TIMEOUT_EN, TIMEOUT_CICLOS=16, no peca_ok -> erro=1 after 16 cycles in REQUEST, pedido=0; iniciar -> REQUEST, erro=0.
